// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline MEM stage. Byte-addressed little-endian data memory
//               with SB/SH/SW stores and LB/LH/LW/LBU/LHU loads, result
//               selection, misalignment detection and the MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [2:0]            funct3M,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  RegWriteM,
    input  logic [4:0]            RdM,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [4:0]            RdW,
    output logic                  RegWriteW,
    output logic                  valid_o,
    output logic                  misaligned_o
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Byte-wide storage; contents deliberately survive reset.
    logic [7:0] r_mem [0:c_DEPTH-1];

    logic [ADDR_WIDTH-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0]            w_b0, w_b1, w_b2, w_b3;
    logic                  w_active;
    logic                  w_is_half;
    logic                  w_is_word;
    logic                  w_mem_access;
    logic                  w_misaligned;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_unused_addr_bits;

    // Only the low address bits index the memory; the rest are don't-care.
    assign w_unused_addr_bits = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH];

    assign w_a0 = ALUResultM[ADDR_WIDTH-1:0];
    assign w_a1 = w_a0 + ADDR_WIDTH'(1);
    assign w_a2 = w_a0 + ADDR_WIDTH'(2);
    assign w_a3 = w_a0 + ADDR_WIDTH'(3);

    // Asynchronous read: reflects contents before this cycle's edge.
    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    assign w_active     = valid_i & ~stall_i & ~flush_i;
    assign w_is_half    = (funct3M[1:0] == 2'b01);
    assign w_is_word    = (funct3M[1:0] == 2'b10);
    assign w_mem_access = MemWriteM | (ResultSrcM == 2'b01);
    assign w_misaligned = valid_i & w_mem_access &
                          ((w_is_half & ALUResultM[0]) |
                           (w_is_word & (ALUResultM[1:0] != 2'b00)));

    // rst_n gates the write so nothing lands in memory while reset is held.
    assign w_we = rst_n & w_active & MemWriteM & ~w_misaligned;

    // Load formatting: size and sign extension selected by funct3.
    always_comb begin
        w_load_data = '0;
        case (funct3M)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_b0[7]}}, w_b0};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_b1[7]}}, w_b1, w_b0};
            3'b010:  w_load_data = {w_b3, w_b2, w_b1, w_b0};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_b0};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_b1, w_b0};
            default: w_load_data = '0;
        endcase
    end

    // Writeback result select.
    always_comb begin
        w_result = ALUResultM;
        case (ResultSrcM)
            2'b01:   w_result = w_load_data;
            2'b10:   w_result = PCPlus4M;
            default: w_result = ALUResultM;
        endcase
    end

    // Store path: little-endian byte lanes, width by funct3.
    always_ff @(posedge clk) begin
        if (w_we) begin
            case (funct3M)
                3'b000: begin
                    r_mem[w_a0] <= WriteDataM[7:0];
                end
                3'b001: begin
                    r_mem[w_a0] <= WriteDataM[7:0];
                    r_mem[w_a1] <= WriteDataM[15:8];
                end
                3'b010: begin
                    r_mem[w_a0] <= WriteDataM[7:0];
                    r_mem[w_a1] <= WriteDataM[15:8];
                    r_mem[w_a2] <= WriteDataM[23:16];
                    r_mem[w_a3] <= WriteDataM[31:24];
                end
                default: ;
            endcase
        end
    end

    // MEM/WB register: flush beats stall, stall holds, idle loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ResultW      <= '0;
            RdW          <= '0;
            RegWriteW    <= 1'b0;
            valid_o      <= 1'b0;
            misaligned_o <= 1'b0;
        end else if (flush_i || (!stall_i && !valid_i)) begin
            ResultW      <= '0;
            RdW          <= '0;
            RegWriteW    <= 1'b0;
            valid_o      <= 1'b0;
            misaligned_o <= 1'b0;
        end else if (w_active) begin
            ResultW      <= w_result;
            RdW          <= RdM;
            RegWriteW    <= RegWriteM & ~w_misaligned;
            valid_o      <= 1'b1;
            misaligned_o <= w_misaligned;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Self-checking bench for memory_stage; expected WB contents
//               are queued as stimulus is applied and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, stall_i, flush_i;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [2:0]  funct3M;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        RegWriteM;
    logic [4:0]  RdM;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW, valid_o, misaligned_o;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
        logic        v;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [39:0] wb;
    int          checks = 0;
    int          errors = 0;

    assign wb = {ResultW, RdW, RegWriteW, valid_o, misaligned_o};

    memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .funct3M(funct3M), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RdM(RdM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .valid_o(valid_o), .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw);
        valid_i = v; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc; RdM = rd; RegWriteM = rw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        drive(1, 0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 5'd9, 1);
        sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        tick(); tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL reset_state got=%h exp=%h", wb, e); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        drive(1, 0, 2'b00, 3'b000, 32'hA5A5_0001, 32'h0, 32'h0, 5'd1, 1);
        sb.push_back('{32'hA5A5_0001, 5'd1, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL first_capture got=%h exp=%h", wb, e); end
        drive(1, 0, 2'b11, 3'b010, 32'h0000_0777, 32'h0, 32'h104, 5'd2, 1);
        sb.push_back('{32'h0000_0777, 5'd2, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL src11_alu got=%h exp=%h", wb, e); end
        drive(1, 0, 2'b10, 3'b000, 32'h0000_0777, 32'h0, 32'h0000_0104, 5'd1, 1);
        sb.push_back('{32'h0000_0104, 5'd1, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL pcplus4 got=%h exp=%h", wb, e); end
    endtask

    task automatic test_store_load();
        drive(1, 1, 2'b00, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'd0, 0);
        sb.push_back('{32'h10, 5'd0, 1'b0, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL sw_10 got=%h exp=%h", wb, e); end
        drive(1, 0, 2'b01, 3'b010, 32'h10, 32'h0, 32'h0, 5'd5, 1);
        sb.push_back('{32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL lw_new_data got=%h exp=%h", wb, e); end
        // Store with load select in the same cycle observes the old word.
        drive(1, 1, 2'b01, 3'b010, 32'h10, 32'h1234_5678, 32'h0, 5'd0, 0);
        sb.push_back('{32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL same_cycle_old got=%h exp=%h", wb, e); end
        drive(1, 0, 2'b01, 3'b010, 32'h10, 32'h0, 32'h0, 5'd6, 1);
        sb.push_back('{32'h1234_5678, 5'd6, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL next_cycle_new got=%h exp=%h", wb, e); end
    endtask

    task automatic test_byte_half();
        logic [2:0]  f3  [5];
        logic [31:0] adr [5];
        logic [31:0] res [5];
        drive(1, 1, 2'b00, 3'b010, 32'h20, 32'h0000_0000, 32'h0, 5'd0, 0);
        tick();
        // SB takes only the low byte of the store data.
        drive(1, 1, 2'b00, 3'b000, 32'h21, 32'hAAAA_AA80, 32'h0, 5'd0, 0);
        sb.push_back('{32'h21, 5'd0, 1'b0, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL sb_21 got=%h exp=%h", wb, e); end
        f3[0] = 3'b000; adr[0] = 32'h21;       res[0] = 32'hFFFF_FF80;
        f3[1] = 3'b100; adr[1] = 32'h21;       res[1] = 32'h0000_0080;
        f3[2] = 3'b001; adr[2] = 32'h20;       res[2] = 32'hFFFF_8000;
        f3[3] = 3'b101; adr[3] = 32'h20;       res[3] = 32'h0000_8000;
        f3[4] = 3'b100; adr[4] = 32'hFFFF_F021; res[4] = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2'b01, f3[i], adr[i], 32'h0, 32'h0, 5'(10 + i), 1);
            sb.push_back('{res[i], 5'(10 + i), 1'b1, 1'b1, 1'b0});
            tick();
            e = sb.pop_front(); checks++;
            if (wb !== e) begin errors++; $display("FAIL load_fmt[%0d] got=%h exp=%h", i, wb, e); end
        end
    endtask

    task automatic test_misaligned();
        drive(1, 1, 2'b00, 3'b010, 32'h12, 32'h1111_1111, 32'h0, 5'd0, 0);
        sb.push_back('{32'h12, 5'd0, 1'b0, 1'b1, 1'b1});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL sw_misaligned got=%h exp=%h", wb, e); end
        drive(1, 0, 2'b01, 3'b010, 32'h10, 32'h0, 32'h0, 5'd7, 1);
        sb.push_back('{32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL no_write_misaligned got=%h exp=%h", wb, e); end
        // Misaligned halfword load: only the control fields are defined.
        drive(1, 0, 2'b01, 3'b001, 32'h21, 32'h0, 32'h0, 5'd8, 1);
        sb.push_back('{32'h0, 5'd8, 1'b0, 1'b1, 1'b1});
        tick();
        e = sb.pop_front(); checks++;
        if (wb[7:0] !== e[7:0]) begin errors++; $display("FAIL lh_misaligned got=%h exp=%h", wb[7:0], e[7:0]); end
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 5'd3, 1);
        sb.push_back('{32'h1234, 5'd3, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL pre_stall got=%h exp=%h", wb, e); end
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b00, 3'b010, 32'h10, 32'h9999_9999, 32'h0, 5'(20 + i), 1);
            sb.push_back('{32'h1234, 5'd3, 1'b1, 1'b1, 1'b0});
            tick();
            e = sb.pop_front(); checks++;
            if (wb !== e) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, wb, e); end
        end
        flush_i = 1'b1;
        sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL flush_over_stall got=%h exp=%h", wb, e); end
        stall_i = 1'b0;
        drive(1, 1, 2'b00, 3'b010, 32'h10, 32'h7777_7777, 32'h0, 5'd4, 1);
        tick();
        flush_i = 1'b0;
        drive(1, 0, 2'b01, 3'b010, 32'h10, 32'h0, 32'h0, 5'd9, 1);
        sb.push_back('{32'h1234_5678, 5'd9, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL no_write_stall_flush got=%h exp=%h", wb, e); end
        drive(0, 1, 2'b00, 3'b010, 32'h10, 32'h6666_6666, 32'h0, 5'd9, 1);
        sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL invalid_bubble got=%h exp=%h", wb, e); end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 2'b00, 3'b000, 32'hCAFE, 32'h0, 32'h0, 5'd7, 1);
        tick();
        stall_i = 1'b1;
        sb.push_back('{32'hCAFE, 5'd7, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL held_before_reset got=%h exp=%h", wb, e); end
        #3;
        rst_n = 1'b0;
        #1;
        sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL async_clear got=%h exp=%h", wb, e); end
        // A store presented across an edge during reset must not land.
        stall_i = 1'b0;
        drive(1, 1, 2'b00, 3'b010, 32'h10, 32'h5555_5555, 32'h0, 5'd1, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 0, 2'b01, 3'b010, 32'h10, 32'h0, 32'h0, 5'd5, 1);
        sb.push_back('{32'h1234_5678, 5'd5, 1'b1, 1'b1, 1'b0});
        tick();
        e = sb.pop_front(); checks++;
        if (wb !== e) begin errors++; $display("FAIL mem_kept_over_reset got=%h exp=%h", wb, e); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_byte_half();
        test_misaligned();
        test_stall_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
